pe_col_drain: RTL and testbench
===============================

# pe_col_drain

Column result drain for the systolic PE array. It sits directly below the bottom PE of one column and captures that PE's partial-sum stream (`o_down_data`) qualified by its delayed pop strobe (`o_pop_vld`). Each word is requantized to the activation width with round-half-up, a right shift and unsigned saturation. Words are tagged with a tile-end marker and buffered in a small FIFO behind a valid/ready output handshake. The PE chain has no backpressure, so the drain never stalls its input: when the FIFO is full, incoming words are dropped and flagged.

## Interface
Parameters:
- `IN_WIDTH`, 24, width of the partial sum from the PE column; matches the PE output width.
- `OUT_WIDTH`, 8, width of the requantized result.
- `SHIFT_WIDTH`, 5, width of the shift configuration.
- `LEN_WIDTH`, 8, width of the tile-length configuration.
- `DEPTH`, 8, number of FIFO entries; must be a power of two, at least 2.

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1, the single clock; all state updates on its rising edge.
- `rst`, input, 1, synchronous active-low reset; 0 resets the block at the next rising edge.
- `i_vld`, input, 1, input word valid; driven by the bottom PE's `o_pop_vld`.
- `i_data`, input, IN_WIDTH, unsigned partial sum; driven by the bottom PE's `o_down_data`.
- `i_cfg_shift`, input, SHIFT_WIDTH, right-shift amount, 0..IN_WIDTH.
- `i_cfg_len`, input, LEN_WIDTH, tile length minus one; a tile holds `i_cfg_len+1` words.
- `o_vld`, output, 1, a result is available at the FIFO head.
- `o_data`, output, OUT_WIDTH, the head result; reads 0 whenever `o_vld` is 0.
- `o_last`, output, 1, the head word is the last word of its tile; reads 0 whenever `o_vld` is 0.
- `i_rdy`, input, 1, the consumer accepts the head word.
- `o_count`, output, $clog2(DEPTH)+1, current FIFO occupancy.
- `o_full`, output, 1, `o_count == DEPTH`.
- `o_overflow`, output, 1, sticky flag: at least one word was dropped since reset.

## Operation
- **S1 register.** When `i_vld`=1, S1 captures `i_data`, `i_cfg_shift` and a valid bit. The round term is added here: `sum = i_data + (shift ? 1<<(shift-1) : 0)`, computed at IN_WIDTH+1 bits, so there is no wrap.
- **S2 register.**
  - Shift: `q = sum >> shift`.
  - Saturate: if `q > 2^OUT_WIDTH-1`, the output is `2^OUT_WIDTH-1`; otherwise it is `q[OUT_WIDTH-1:0]`.
  - Tag: `last = (tile_cnt == i_cfg_len)`.
- **Tile counter.** It increments once per S2-valid word, whether that word is stored or dropped, so framing stays aligned. It wraps to 0 after the tile's last word.
- **Push and drop.** A word is pushed when S2 is valid and (`o_count < DEPTH` or a pop happens in the same cycle). Otherwise the word is dropped and `o_overflow` is set to 1; it clears only on reset.
- **Pop.** A pop happens when `o_vld && i_rdy`. The head advances and `o_data`/`o_last` show the next entry in the same cycle, or 0 if the FIFO becomes empty.
- **Pointer wrap.** Read and write pointers wrap modulo DEPTH.
- **Same-cycle push and pop.**
  - When full: both happen and `o_count` holds at DEPTH.
  - When empty: only the push happens; a pop requires `o_vld`=1.
- **Configuration.** `i_cfg_shift` is sampled per word at S1. `i_cfg_len` must be held stable while a tile is in flight; changing it mid-tile has undefined framing.
- **Reset (`rst`=0), including mid-operation.** In-flight S1/S2 words are discarded.

  | State | Reset value |
  |---|---|
  | S1/S2 valid bits | 0 |
  | Pointers | 0 |
  | `o_count` | 0 |
  | `tile_cnt` | 0 |
  | `o_overflow` | 0 |
  | `o_vld`, `o_data`, `o_last`, `o_full` | 0 |

## Timing
- An `i_vld` word sampled at edge E is in S1 after E and in S2 after E+1. It is written to the FIFO at edge E+2.
- With an empty FIFO, `o_vld` rises in the cycle after edge E+2. That is a 3-cycle latency from `i_vld` to `o_vld`.
- Back-to-back input at 1 word per cycle is sustained with `i_rdy`=1.
- `o_count`, `o_full` and `o_overflow` update at the edge where the push, pop or drop happens.
- In the first cycle after `rst` returns to 1, all outputs still show their reset values. `i_vld` is honoured from that cycle on.

## Test plan
1. **Rounding.** shift=1, `i_data` = 3 then 2, `i_rdy`=1 → `o_data` = 2 then 1. `o_vld` rises 3 cycles after the first `i_vld`.
2. **Scaling and saturation.**
   - shift=4, data 0x000128 → 0x13.
   - shift=0, data 300 → 0xFF.
   - shift=8, data 0xFFFFFF → 0xFF.
   - shift=24, data 0x7FFFFF → 0x00.
3. **Tile framing.** `i_cfg_len`=3, 8 consecutive words → `o_last`=1 on the 4th and 8th outputs only; `tile_cnt` returns to 0.
4. **Backpressure and overflow.** `i_rdy`=0, 10 words 1..10, DEPTH=8.
   - Result: `o_count`=8, `o_full`=1, words 9 and 10 dropped, `o_overflow`=1.
   - Then set `i_rdy`=1 → outputs 1..8 in order, `o_count` reaches 0, `o_overflow` stays 1.
5. **Full with simultaneous push and pop.** FIFO full, `i_rdy`=1 while a continuous input stream arrives → no drop, `o_count` stays 8, output order preserved.
6. **Reset mid-operation.** `rst`=0 with 5 words buffered and 2 in flight.
   - Next cycle: `o_vld`=0, `o_count`=0, `o_overflow`=0.
   - Then a fresh 4-word tile with `i_cfg_len`=3 → `o_last` on its 4th word.

Source files
------------

// File: rtl/pe_col_drain.sv
// Column drain: requantizes the bottom-PE partial-sum stream,
// tags tile ends and buffers results behind a valid/ready port.
module pe_col_drain #(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int LEN_WIDTH   = 8,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [IN_WIDTH-1:0]        i_data,
  input  logic [SHIFT_WIDTH-1:0]     i_cfg_shift,
  input  logic [LEN_WIDTH-1:0]       i_cfg_len,
  output logic                       o_vld,
  output logic [OUT_WIDTH-1:0]       o_data,
  output logic                       o_last,
  input  logic                       i_rdy,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [OUT_WIDTH-1:0] SAT = '1;

  logic                   s1_vld;
  logic [IN_WIDTH:0]      s1_sum;
  logic [SHIFT_WIDTH-1:0] s1_shift;

  logic                   s2_vld;
  logic [OUT_WIDTH-1:0]   s2_data;
  logic                   s2_last;
  logic [LEN_WIDTH-1:0]   tile_cnt;

  logic [IN_WIDTH:0]      rnd;
  logic [IN_WIDTH:0]      q;
  logic [OUT_WIDTH-1:0]   sat_q;
  logic                   tile_last;

  logic [OUT_WIDTH-1:0]   mem_d [DEPTH];
  logic                   mem_l [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   ovf;
  logic                   pop;
  logic                   push;
  logic                   drop;

  always_comb begin
    rnd = '0;
    if (i_cfg_shift != '0)
      rnd = (IN_WIDTH+1)'(1) << (i_cfg_shift - SHIFT_WIDTH'(1));
    q         = s1_sum >> s1_shift;
    sat_q     = (|q[IN_WIDTH:OUT_WIDTH]) ? SAT : q[OUT_WIDTH-1:0];
    tile_last = (tile_cnt == i_cfg_len);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
    end else begin
      s1_vld <= i_vld;
      if (i_vld) begin
        s1_sum   <= {1'b0, i_data} + rnd;
        s1_shift <= i_cfg_shift;
      end
    end
  end

  // tile_cnt advances for every word, stored or dropped, to keep framing
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_vld   <= 1'b0;
      s2_data  <= '0;
      s2_last  <= 1'b0;
      tile_cnt <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data  <= sat_q;
        s2_last  <= tile_last;
        tile_cnt <= tile_last ? '0 : tile_cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign pop  = o_vld & i_rdy;
  assign push = s2_vld & ((count != FULL_C) | pop);
  assign drop = s2_vld & ~push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= s2_data;
      mem_l[wr_ptr] <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    o_vld      = (count != '0);
    o_data     = o_vld ? mem_d[rd_ptr] : '0;
    o_last     = o_vld ? mem_l[rd_ptr] : 1'b0;
    o_count    = count;
    o_full     = (count == FULL_C);
    o_overflow = ovf;
  end

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: randomized and directed stimulus against a
// word-level reference model with a queue-based scoreboard.
module tb_pe_col_drain;

  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        rst = 0;
  logic        i_vld = 0;
  logic [23:0] i_data = '0;
  logic [4:0]  i_cfg_shift = '0;
  logic [7:0]  i_cfg_len = '0;
  logic        o_vld;
  logic [7:0]  o_data;
  logic        o_last;
  logic        i_rdy = 0;
  logic [3:0]  o_count;
  logic        o_full;
  logic        o_overflow;

  pe_col_drain dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_data(i_data),
    .i_cfg_shift(i_cfg_shift), .i_cfg_len(i_cfg_len),
    .o_vld(o_vld), .o_data(o_data), .o_last(o_last),
    .i_rdy(i_rdy), .o_count(o_count), .o_full(o_full),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         last;
    int         due;
  } word_t;

  word_t pipe[$];
  word_t mq[$];
  bit    m_ovf = 0;
  int    m_idx = 0;
  int    cyc = 0;
  bit    armed = 0;
  int    checks = 0;
  int    errors = 0;

  // round-to-nearest (half up) of d / 2^sh, then clamp to 8 bits
  function automatic logic [7:0] expect_q(longint d, int sh);
    longint p;
    longint r;
    p = longint'(1) << sh;
    r = (2 * d + p) / (2 * p);
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  // Reference model: words land in the FIFO two edges after sampling.
  always @(posedge clk) begin
    word_t w;
    int    sz;
    bit    pp;
    cyc++;
    if (!rst) begin
      pipe.delete();
      mq.delete();
      m_ovf = 0;
      m_idx = 0;
      armed = 1;
    end else begin
      sz = mq.size();
      pp = (sz > 0) && i_rdy;
      if (pp) void'(mq.pop_front());
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
        w = pipe.pop_front();
        if (sz < DEPTH || pp) mq.push_back(w);
        else m_ovf = 1;
      end
      if (i_vld) begin
        w.d    = expect_q(longint'(i_data), int'(i_cfg_shift));
        w.last = (m_idx == int'(i_cfg_len));
        w.due  = cyc + 2;
        m_idx  = w.last ? 0 : m_idx + 1;
        pipe.push_back(w);
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: compares the DUT head/status against the model queue.
  always @(negedge clk) begin
    if (armed) begin
      chk("o_vld", longint'(o_vld), longint'(mq.size() != 0));
      chk("o_count", longint'(o_count), longint'(mq.size()));
      chk("o_full", longint'(o_full), longint'(mq.size() == DEPTH));
      chk("o_overflow", longint'(o_overflow), longint'(m_ovf));
      if (mq.size() != 0) begin
        chk("o_data", longint'(o_data), longint'(mq[0].d));
        chk("o_last", longint'(o_last), longint'(mq[0].last));
      end else begin
        chk("o_data_idle", longint'(o_data), 0);
        chk("o_last_idle", longint'(o_last), 0);
      end
    end
  end

  task automatic step(bit v, logic [23:0] d, logic [4:0] sh, bit rdy);
    i_vld       = v;
    i_data      = d;
    i_cfg_shift = sh;
    i_rdy       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) step(0, '0, '0, rdy);
  endtask

  initial begin
    rst = 0;
    idle(3, 0);
    rst = 1;

    // rounding
    i_cfg_len = 8'd1;
    step(1, 24'd3, 5'd1, 1);
    step(1, 24'd2, 5'd1, 1);
    idle(5, 1);

    // scaling and saturation
    i_cfg_len = 8'd3;
    step(1, 24'h000128, 5'd4, 1);
    step(1, 24'd300, 5'd0, 1);
    step(1, 24'hFFFFFF, 5'd8, 1);
    step(1, 24'h7FFFFF, 5'd24, 1);
    idle(5, 1);

    // tile framing: 8 words, len 3
    for (int i = 0; i < 8; i++)
      step(1, 24'($urandom_range(0, 4095)), 5'd4, 1);
    idle(5, 1);

    // backpressure and overflow: 10 words, 2 tiles of 5
    i_cfg_len = 8'd4;
    for (int i = 1; i <= 10; i++)
      step(1, 24'(i), 5'd0, 0);
    idle(4, 0);
    idle(12, 1);

    // full with simultaneous push and pop
    i_cfg_len = 8'd3;
    for (int i = 0; i < 24; i++)
      step(1, 24'(i + 16), 5'd0, i >= 10);
    idle(12, 1);

    // reset mid-operation: 5 buffered, 2 in flight
    i_cfg_len = 8'd6;
    for (int i = 0; i < 7; i++)
      step(1, 24'(i + 40), 5'd0, 0);
    rst = 0;
    idle(1, 0);
    rst = 1;
    idle(1, 0);
    i_cfg_len = 8'd3;
    for (int i = 0; i < 4; i++)
      step(1, 24'(i + 60), 5'd1, 1);
    idle(6, 1);

    // randomized traffic, 5-word tiles
    i_cfg_len = 8'd4;
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] d;
      d = ($urandom_range(0, 1) == 1) ? 24'($urandom)
                                      : 24'($urandom_range(0, 1023));
      step($urandom_range(0, 9) < 7, d, 5'($urandom_range(0, 24)),
           $urandom_range(0, 9) < 6);
    end
    idle(20, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
